vga_sync_gen: RTL



---
 rtl/vga_sync_gen_pkg.sv | 38 +++
 rtl/vga_sync_gen_mod_m_counter.sv | 34 +++
 rtl/vga_sync_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - shared VGA timing constants and colour codes
package vga_sync_gen_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    // 640x480@60 Hz with a 25 MHz pixel clock derived from 50 MHz
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int scan_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = scan_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = scan_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // 3-bit RGB colour codes used by the background and sprite generators
    typedef enum logic [2:0] {
        NEGRO    = 3'b000,
        AZUL     = 3'b001,
        VERDE    = 3'b010,
        CIAN     = 3'b011,
        ROJO     = 3'b100,
        MAGENTA  = 3'b101,
        AMARILLO = 3'b110,
        BLANCO   = 3'b111
    } colour_t;

endpackage

// File: rtl/vga_sync_gen_mod_m_counter.sv
// rtl/vga_sync_gen_mod_m_counter.sv - generic wrap-at-M counter with enable
// count_next is exposed so callers can decode the value the counter is about to take.
module mod_m_counter #(
    parameter int M = 2,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         max_tick
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    assign max_tick = (count == LAST);

    always_comb begin
        count_next = count;
        if (en) begin
            count_next = max_tick ? '0 : count + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480 VGA sync, blanking and scan-coordinate generator
// Sync/blank outputs are decoded from the counters' next values so they align with pixel_x/pixel_y.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = scan_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = scan_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [COORD_W-1:0] H_DISP_END  = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] H_SYNC_BEG  = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_LAST = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_DISP_END  = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] V_SYNC_BEG  = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_LAST = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_totals
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit scan counters");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0]   div_count;
    logic [DIV_W-1:0]   div_count_next;
    logic               div_max;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] h_next;
    logic               h_max;
    logic [COORD_W-1:0] v_count;
    logic [COORD_W-1:0] v_next;
    logic               v_max;
    logic               v_en;
    logic               div_unused;

    assign div_unused = ^{div_count, div_count_next};
    assign v_en       = h_max & p_tick;

    mod_m_counter #(.M(CLK_DIV), .W(DIV_W)) u_div (
        .clk        (clk),
        .reset      (reset),
        .en         (1'b1),
        .count      (div_count),
        .count_next (div_count_next),
        .max_tick   (div_max)
    );

    mod_m_counter #(.M(H_TOTAL), .W(COORD_W)) u_h (
        .clk        (clk),
        .reset      (reset),
        .en         (p_tick),
        .count      (h_count),
        .count_next (h_next),
        .max_tick   (h_max)
    );

    mod_m_counter #(.M(V_TOTAL), .W(COORD_W)) u_v (
        .clk        (clk),
        .reset      (reset),
        .en         (v_en),
        .count      (v_count),
        .count_next (v_next),
        .max_tick   (v_max)
    );

    assign pixel_x = h_count;
    assign pixel_y = v_count;

    // Decoded outputs only move on pixel edges, so the first pixel after reset stays blanked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_tick      <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            p_tick      <= div_max;
            frame_start <= p_tick & h_max & v_max;
            if (p_tick) begin
                video_on <= (h_next < H_DISP_END) && (v_next < V_DISP_END);
                hsync    <= !((h_next >= H_SYNC_BEG) && (h_next <= H_SYNC_LAST));
                vsync    <= !((v_next >= V_SYNC_BEG) && (v_next <= V_SYNC_LAST));
            end
        end
    end

endmodule
